// File: rtl/game_countdown_timer.sv
// game_countdown_timer
//   Level countdown timer (MM:SS). Counts down the remaining level time on the
//   one-second tick and drives four BCD digits to the HUD. It also flags low time
//   and expiry to game control, and handles start, pause, resume, bonus time and
//   reload.
//
//   Ports
//     clk        system clock
//     resetN     asynchronous, active-low reset
//     tick       one-clock one-second strobe
//     start      pulse: start from IDLE / resume from PAUSED
//     pause      pulse: pause while RUNNING
//     load       pulse: reload initial time and return to IDLE (highest priority)
//     add_bonus  pulse: add BONUS_SECS, saturating at 99:59
//     min_tens, min_ones, sec_tens, sec_ones   registered BCD digits of remaining time
//     running    state is RUNNING
//     time_up    one-clock pulse when the count reaches 0
//     expired    state is EXPIRED
//     warning    remaining time is in 1..WARN_SECS while RUNNING or PAUSED
//     blink      HUD blink phase while warning
//
//   state   | meaning
//   IDLE    | loaded, waiting for start; ticks ignored
//   RUNNING | each tick consumes one second
//   PAUSED  | ticks ignored, waiting for start to resume
//   EXPIRED | count is 0; only load leaves this state
module game_countdown_timer #(
  parameter int INIT_MIN   = 3,
  parameter int INIT_SEC   = 0,
  parameter int WARN_SECS  = 10,
  parameter int BONUS_SECS = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic       add_bonus,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       time_up,
  output logic       expired,
  output logic       warning,
  output logic       blink
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  localparam logic [12:0] INIT    = 13'(INIT_MIN * 60 + INIT_SEC);
  localparam logic [13:0] MAX_CNT = 14'd5999;
  localparam logic [13:0] BONUS   = 14'(BONUS_SECS);
  localparam logic [12:0] WARN    = 13'(WARN_SECS);
  localparam logic [3:0]  INIT_MT = 4'(INIT_MIN / 10);
  localparam logic [3:0]  INIT_MO = 4'(INIT_MIN % 10);
  localparam logic [3:0]  INIT_ST = 4'(INIT_SEC / 10);
  localparam logic [3:0]  INIT_SO = 4'(INIT_SEC % 10);

  state_t      state, state_nxt;
  logic [12:0] cnt, cnt_nxt;
  logic        time_up_nxt;
  logic        blink_r, blink_nxt;
  logic [13:0] bonus_sum, bonus_tick_sum;
  logic [12:0] bonus_cnt, bonus_tick_cnt;
  logic [6:0]  mins, secs;
  logic        warn_nxt;

  // 14-bit sums so the saturation compare sees the carry out of 13 bits.
  assign bonus_sum      = {1'b0, cnt} + BONUS;
  assign bonus_tick_sum = bonus_sum - 14'd1;
  assign bonus_cnt      = (bonus_sum > MAX_CNT) ? 13'd5999 : 13'(bonus_sum);
  assign bonus_tick_cnt = (bonus_tick_sum > MAX_CNT) ? 13'd5999 : 13'(bonus_tick_sum);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      cnt     <= INIT;
      time_up <= 1'b0;
      blink_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      time_up <= time_up_nxt;
      blink_r <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    time_up_nxt = 1'b0;
    blink_nxt   = warning ? blink_r : 1'b0;
    if (load) begin
      state_nxt = IDLE;
      cnt_nxt   = INIT;
      blink_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (add_bonus) cnt_nxt = bonus_cnt;
          if (start) state_nxt = RUNNING;
        end
        RUNNING: begin
          if (pause) state_nxt = PAUSED;
          if (tick && warning) blink_nxt = ~blink_r;
          // A bonus landing on the same tick absorbs the decrement, so it can never expire.
          if (tick && add_bonus) cnt_nxt = bonus_tick_cnt;
          else if (tick && cnt == 13'd1) begin
            cnt_nxt     = 13'd0;
            state_nxt   = EXPIRED;
            time_up_nxt = 1'b1;
          end else if (tick) cnt_nxt = cnt - 13'd1;
          else if (add_bonus) cnt_nxt = bonus_cnt;
        end
        PAUSED: begin
          if (add_bonus) cnt_nxt = bonus_cnt;
          if (start) state_nxt = RUNNING;
        end
        EXPIRED: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign running = (state == RUNNING);
  assign expired = (state == EXPIRED);
  // The blink register can lag warning's fall by a cycle; gating keeps the output at 0.
  assign blink   = blink_r & warning;

  assign mins     = 7'(cnt / 13'd60);
  assign secs     = 7'(cnt % 13'd60);
  assign warn_nxt = ((state == RUNNING) || (state == PAUSED)) && (cnt != 13'd0) && (cnt <= WARN);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      min_tens <= INIT_MT;
      min_ones <= INIT_MO;
      sec_tens <= INIT_ST;
      sec_ones <= INIT_SO;
      warning  <= 1'b0;
    end else begin
      min_tens <= 4'(mins / 7'd10);
      min_ones <= 4'(mins % 7'd10);
      sec_tens <= 4'(secs / 7'd10);
      sec_ones <= 4'(secs % 7'd10);
      warning  <= warn_nxt;
    end
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
module tb_game_countdown_timer;

  localparam int INIT_MIN = 0;
  localparam int INIT_SEC = 12;
  localparam int WARN     = 10;
  localparam int BONUS    = 5;
  localparam int INIT     = INIT_MIN * 60 + INIT_SEC;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic clk = 1'b0;
  logic resetN;
  logic tick, start, pause, load, add_bonus;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, time_up, expired, warning, blink;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining seconds, mode, and the one-cycle-delayed display view.
  int m_cnt, m_mode, m_disp;
  bit m_tu, m_warn, m_blink;

  game_countdown_timer #(
    .INIT_MIN(INIT_MIN), .INIT_SEC(INIT_SEC), .WARN_SECS(WARN), .BONUS_SECS(BONUS)
  ) dut (
    .clk(clk), .resetN(resetN), .tick(tick), .start(start), .pause(pause),
    .load(load), .add_bonus(add_bonus),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .time_up(time_up), .expired(expired), .warning(warning), .blink(blink)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int c);
    int m, s;
    m = c / 60;
    s = c % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int add_sat(input int c, input int d);
    return (c + d > 5999) ? 5999 : c + d;
  endfunction

  task automatic model_reset();
    m_cnt = INIT; m_mode = M_IDLE; m_disp = INIT;
    m_tu = 0; m_warn = 0; m_blink = 0;
  endtask

  task automatic model_edge(input bit t, s, p, l, b);
    bit warn_old;
    warn_old = m_warn;
    m_warn   = (m_mode == M_RUN || m_mode == M_PAUSE) && m_cnt > 0 && m_cnt <= WARN;
    m_disp   = m_cnt;
    m_tu     = 0;
    if (l) begin
      m_cnt = INIT; m_mode = M_IDLE; m_blink = 0;
    end else begin
      if (!warn_old) m_blink = 0;
      else if (m_mode == M_RUN && t) m_blink = !m_blink;
      case (m_mode)
        M_IDLE: begin
          if (b) m_cnt = add_sat(m_cnt, BONUS);
          if (s) m_mode = M_RUN;
        end
        M_RUN: begin
          if (t && b) m_cnt = add_sat(m_cnt, BONUS - 1);
          else if (t) m_cnt = m_cnt - 1;
          else if (b) m_cnt = add_sat(m_cnt, BONUS);
          if (t && !b && m_cnt == 0) begin
            m_mode = M_EXP; m_tu = 1;
          end else if (p) m_mode = M_PAUSE;
        end
        M_PAUSE: begin
          if (b) m_cnt = add_sat(m_cnt, BONUS);
          if (s) m_mode = M_RUN;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("digits",  {min_tens, min_ones, sec_tens, sec_ones}, to_bcd(m_disp));
    check("running", 16'(running), 16'(m_mode == M_RUN));
    check("expired", 16'(expired), 16'(m_mode == M_EXP));
    check("time_up", 16'(time_up), 16'(m_tu));
    check("warning", 16'(warning), 16'(m_warn));
    check("blink",   16'(blink),   16'(m_blink & m_warn));
  endtask

  task automatic step(input bit t, s, p, l, b);
    @(negedge clk);
    check_outputs();
    tick = t; start = s; pause = p; load = l; add_bonus = b;
    @(posedge clk);
    if (resetN) model_edge(t, s, p, l, b);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    #3 resetN = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    #2 resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b1;
    tick = 0; start = 0; pause = 0; load = 0; add_bonus = 0;
    @(posedge clk);
    apply_reset();
    idle_steps(2);

    // Ticks and pause ignored in IDLE, then basic countdown and digit latency.
    ticks(3);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    ticks(3);
    idle_steps(2);

    // Pause freezes, pause wins over start while running, resume via start.
    step(0, 1, 1, 0, 0);
    ticks(5);
    step(0, 1, 0, 0, 0);
    ticks(1);
    idle_steps(1);

    // Into warning region: warning and blink per tick, then hold across pause.
    ticks(4);
    step(0, 0, 1, 0, 0);
    ticks(2);
    step(0, 1, 0, 0, 0);
    ticks(1);
    idle_steps(1);

    // Load mid-run wins over everything else that cycle.
    step(1, 1, 1, 1, 1);
    idle_steps(2);

    // Saturation at 99:59 via bonus pulses in IDLE, then tick to 99:58 and bonus.
    for (int i = 0; i < 1200; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    ticks(1);
    step(0, 0, 0, 0, 1);
    idle_steps(1);
    step(1, 0, 0, 0, 1);
    idle_steps(1);
    step(0, 0, 0, 1, 0);

    // cnt=1 with tick+bonus in the same cycle: no expiry.
    step(0, 1, 0, 0, 0);
    ticks(11);
    step(1, 0, 0, 0, 1);
    idle_steps(2);

    // Run down to expiry with a pause colliding on the final tick.
    ticks(4);
    step(1, 0, 1, 0, 0);
    idle_steps(2);
    ticks(2);
    step(0, 1, 1, 0, 1);
    step(1, 1, 0, 0, 1);
    idle_steps(2);
    step(0, 0, 0, 1, 0);
    idle_steps(1);

    // Randomized traffic with occasional mid-run async reset.
    for (int i = 0; i < 4000; i++) begin
      bit t, s, p, l, b;
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 79) == 0);
      b = ($urandom_range(0, 14) == 0);
      step(t, s, p, l, b);
      if (i % 1500 == 1499) apply_reset();
    end
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
